// File: rtl/red_pitaya_rst_seq.sv
// Reset sequencer and MMCM lock supervisor for the ADC clock domain.
// Optional MMCM re-reset watchdog enabled with `define RST_SEQ_WATCHDOG_EN.
module red_pitaya_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_HOLD   = 1024,
  parameter int STAGGER     = 16,
  parameter int N_OUT       = 3,
  parameter int WD_TIMEOUT  = 65536,
  parameter int PLL_RST_LEN = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pll_locked_i,
  input  logic             soft_rst_i,
  output logic [N_OUT-1:0] rst_n_o,
  output logic             ready_o,
  output logic [15:0]      lock_loss_cnt_o,
  output logic [2:0]       state_o,
  output logic             pll_rst_o
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_PLL_RST   = 3'd4
  } state_e;

  // One shared counter serves the hold, stagger, watchdog and pulse timers.
  localparam int MAX_A   = (LOCK_HOLD > STAGGER) ? LOCK_HOLD : STAGGER;
  localparam int MAX_B   = (WD_TIMEOUT > PLL_RST_LEN) ? WD_TIMEOUT : PLL_RST_LEN;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;

  state_e           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [IDX_W-1:0] r_idx,       w_idx_nxt;
  logic [N_OUT-1:0] r_rst_n,     w_rst_n_nxt;
  logic             r_ready,     w_ready_nxt;
  logic [15:0]      r_loss_cnt,  w_loss_cnt_nxt;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_rst_n_nxt    = r_rst_n;
    w_ready_nxt    = r_ready;
    w_loss_cnt_nxt = r_loss_cnt;

    case (r_state)
      ST_WAIT_LOCK: begin
        w_rst_n_nxt = '0;
        w_ready_nxt = 1'b0;
        if (w_locked_s && !soft_rst_i) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
`ifdef RST_SEQ_WATCHDOG_EN
        else if (r_cnt == CNT_W'(WD_TIMEOUT - 1)) begin
          w_state_nxt = ST_PLL_RST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`else
        else begin
          w_cnt_nxt = '0;
        end
`endif
      end

      ST_HOLD: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (soft_rst_i) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(LOCK_HOLD - 1)) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_RELEASE, ST_RUN: begin
        // Lock loss outranks a soft reset; only losses out of RUN are counted.
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          if (r_state == ST_RUN && r_loss_cnt != 16'hFFFF) begin
            w_loss_cnt_nxt = r_loss_cnt + 16'd1;
          end
        end else if (soft_rst_i) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
        end else if (r_state == ST_RELEASE) begin
          if (r_cnt == CNT_W'(STAGGER - 1)) begin
            w_rst_n_nxt[r_idx] = 1'b1;
            w_cnt_nxt          = '0;
            if (r_idx == IDX_W'(N_OUT - 1)) begin
              w_state_nxt = ST_RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

`ifdef RST_SEQ_WATCHDOG_EN
      ST_PLL_RST: begin
        if (r_cnt == CNT_W'(PLL_RST_LEN - 1)) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif

      default: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_rst_n_nxt = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_WAIT_LOCK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rst_n    <= '0;
      r_ready    <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge next-state values.
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_rst_n    <= w_rst_n_nxt;
      r_ready    <= w_ready_nxt;
      r_loss_cnt <= w_loss_cnt_nxt;
    end
  end

  assign rst_n_o         = r_rst_n;
  assign ready_o         = r_ready;
  assign lock_loss_cnt_o = r_loss_cnt;
  assign state_o         = r_state;

`ifdef RST_SEQ_WATCHDOG_EN
  assign pll_rst_o = (r_state == ST_PLL_RST);
`else
  assign pll_rst_o = 1'b0;
`endif

endmodule
